// File: rtl/ttt_turn_ctrl_if.sv
// Player-side signal bundle of the tic-tac-toe turn controller.
// master = menu/keypad/display side, slave = ttt_turn_ctrl.
interface ttt_turn_ctrl_if;
    logic        is_main;
    logic [3:0]  key_data;
    logic [17:0] board;
    logic        is_turn_o;
    logic [1:0]  result;
    logic [3:0]  move_cnt;
    logic        err;
    logic        busy;

    modport master (
        output is_main, key_data,
        input  board, is_turn_o, result, move_cnt, err, busy
    );

    modport slave (
        input  is_main, key_data,
        output board, is_turn_o, result, move_cnt, err, busy
    );
endinterface

// File: rtl/ttt_turn_ctrl.sv
// Tic-tac-toe turn controller: keypad press -> validate -> commit -> judge.
// The optional per-turn move timeout is compiled in with `define MOVE_TIMEOUT_EN.
module ttt_turn_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 250000000,
    parameter int unsigned CNT_W          = 28
) (
    input  logic           clk,
    input  logic           rst,
    ttt_turn_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE, WAIT_KEY, CHECK, COMMIT, JUDGE, DONE
    } state_e;

    // Winning lines as cell masks (bit k-1 = cell k): rows, columns, diagonals.
    localparam logic [8:0] LINES [8] = '{9'h007, 9'h038, 9'h1C0, 9'h049,
                                         9'h092, 9'h124, 9'h111, 9'h054};

    if (CNT_W < $clog2(TIMEOUT_CYCLES + 1)) begin : g_cnt_w_check
        $error("CNT_W is too narrow to hold TIMEOUT_CYCLES");
    end

    state_e      state_q, state_d;
    logic [17:0] board_q, board_d;
    logic        turn_q, turn_d;
    logic [1:0]  result_q, result_d;
    logic [3:0]  move_cnt_q, move_cnt_d;
    logic [3:0]  code_q, code_d;
    logic [3:0]  key_q, key_d;
    logic        prev_zero_q, prev_zero_d;

    logic        press;
    logic        reject;
    logic        win;
    logic [8:0]  x_mask, o_mask, mover_mask, cell_sel;

    assign key_d       = bus.key_data;
    assign prev_zero_d = (key_q == 4'd0);
    assign press       = prev_zero_q && (key_q != 4'd0);

    always_comb begin
        for (int k = 0; k < 9; k++) begin
            o_mask[k] = board_q[17-2*k];
            x_mask[k] = board_q[16-2*k];
        end
    end

    assign mover_mask = turn_q ? o_mask : x_mask;
    // Codes 10..15 shift the one-hot off the top, leaving no cell selected.
    assign cell_sel   = 9'd1 << (code_q - 4'd1);
    assign reject     = (code_q > 4'd9) || ((cell_sel & (x_mask | o_mask)) != 9'd0);

    always_comb begin
        win = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if ((mover_mask & LINES[i]) == LINES[i]) win = 1'b1;
        end
    end

`ifdef MOVE_TIMEOUT_EN
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             expire;

    assign expire    = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    // Counts only while waiting; every other state zeroes it, so each WAIT_KEY entry starts at 0.
    assign tmo_cnt_d = (state_q == WAIT_KEY && !press && !expire && !bus.is_main)
                       ? tmo_cnt_q + 1'b1 : '0;
`endif

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d    = state_q;
        board_d    = board_q;
        turn_d     = turn_q;
        result_d   = result_q;
        move_cnt_d = move_cnt_q;
        code_d     = code_q;

        case (state_q)
            IDLE: begin
                if (!bus.is_main) state_d = WAIT_KEY;
            end
            WAIT_KEY: begin
                if (press) begin
                    code_d  = key_q;
                    state_d = CHECK;
                end
`ifdef MOVE_TIMEOUT_EN
                else if (expire) begin
                    turn_d = ~turn_q;
                end
`endif
            end
            CHECK: begin
                state_d = reject ? WAIT_KEY : COMMIT;
            end
            COMMIT: begin
                for (int k = 0; k < 9; k++) begin
                    if (cell_sel[k]) begin
                        if (turn_q) board_d[17-2*k] = 1'b1;
                        else        board_d[16-2*k] = 1'b1;
                    end
                end
                move_cnt_d = move_cnt_q + 4'd1;
                state_d    = JUDGE;
            end
            JUDGE: begin
                if (win) begin
                    result_d = turn_q ? 2'b10 : 2'b01;
                    state_d  = DONE;
                end else if (move_cnt_q == 4'd9) begin
                    result_d = 2'b11;
                    state_d  = DONE;
                end else begin
                    turn_d  = ~turn_q;
                    state_d = WAIT_KEY;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Returning to the menu wins over everything, including a half-finished move.
        if (bus.is_main) begin
            state_d    = IDLE;
            board_d    = '0;
            turn_d     = 1'b0;
            result_d   = 2'b00;
            move_cnt_d = 4'd0;
            code_d     = 4'd0;
        end
    end

    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            board_q     <= '0;
            turn_q      <= 1'b0;
            result_q    <= 2'b00;
            move_cnt_q  <= 4'd0;
            code_q      <= 4'd0;
            // Non-zero reset value: a key held through reset looks already held and must be released first.
            key_q       <= 4'hF;
            prev_zero_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            board_q     <= board_d;
            turn_q      <= turn_d;
            result_q    <= result_d;
            move_cnt_q  <= move_cnt_d;
            code_q      <= code_d;
            key_q       <= key_d;
            prev_zero_q <= prev_zero_d;
        end
    end

`ifdef MOVE_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) tmo_cnt_q <= '0;
        else     tmo_cnt_q <= tmo_cnt_d;
    end
`endif

    assign bus.board     = board_q;
    assign bus.is_turn_o = turn_q;
    assign bus.result    = result_q;
    assign bus.move_cnt  = move_cnt_q;
    assign bus.err       = (state_q == CHECK) && reject;
    assign bus.busy      = (state_q == CHECK) || (state_q == COMMIT) || (state_q == JUDGE);

endmodule

// File: tb/tb_ttt_turn_ctrl.sv
// Self-checking bench for ttt_turn_ctrl: directed scenarios plus random games
// compared against a cell-array game model (timeout case runs when MOVE_TIMEOUT_EN is defined).
module tb_ttt_turn_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ttt_turn_ctrl_if bus_if ();

    ttt_turn_ctrl #(
        .TIMEOUT_CYCLES (16),
        .CNT_W          (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int errors = 0;
    int checks = 0;

    // Game model: cells[k-1] = 0 empty, 1 X, 2 O.
    int         cells [9];
    logic       m_turn;
    logic [1:0] m_res;
    int         m_moves;
    bit         m_over;
    int         line3 [8][3] = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9},
                                 '{1, 4, 7}, '{2, 5, 8}, '{3, 6, 9},
                                 '{1, 5, 9}, '{3, 5, 7}};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic m_clear();
        for (int k = 0; k < 9; k++) cells[k] = 0;
        m_turn  = 1'b0;
        m_res   = 2'b00;
        m_moves = 0;
        m_over  = 1'b0;
    endtask

    function automatic logic [17:0] m_board();
        logic [17:0] b;
        b = '0;
        for (int k = 1; k <= 9; k++) begin
            if (cells[k-1] == 1) b[18-2*k] = 1'b1;
            if (cells[k-1] == 2) b[19-2*k] = 1'b1;
        end
        return b;
    endfunction

    function automatic bit m_has_line(input int p);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (cells[line3[i][0]-1] == p && cells[line3[i][1]-1] == p && cells[line3[i][2]-1] == p)
                found = 1'b1;
        end
        return found;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, "_board"}, 32'(bus_if.board), 32'(m_board()));
        check({tag, "_turn"},  32'(bus_if.is_turn_o), 32'(m_turn));
        check({tag, "_res"},   32'(bus_if.result), 32'(m_res));
        check({tag, "_cnt"},   32'(bus_if.move_cnt), 32'(m_moves));
    endtask

    // One key press, observed cycle by cycle through CHECK, COMMIT and JUDGE, then released.
    task automatic do_press(input logic [3:0] code);
        bit take, rej;
        int p;
        take = 1'b0;
        rej  = 1'b0;
        if (!m_over) begin
            if (code >= 4'd1 && code <= 4'd9) begin
                if (cells[code-1] == 0) take = 1'b1;
                else                    rej  = 1'b1;
            end else begin
                rej = 1'b1;
            end
        end
        @(negedge clk) bus_if.key_data = code;
        @(posedge clk);
        @(negedge clk);
        check("err_sample", 32'(bus_if.err), 32'd0);
        check("busy_sample", 32'(bus_if.busy), 32'd0);
        @(negedge clk);
        check("err_check", 32'(bus_if.err), 32'(rej));
        check("busy_check", 32'(bus_if.busy), 32'(take | rej));
        @(negedge clk);
        check("err_commit", 32'(bus_if.err), 32'd0);
        check("busy_commit", 32'(bus_if.busy), 32'(take));
        check_outputs("pre_commit");
        if (take) begin
            cells[code-1] = m_turn ? 2 : 1;
            m_moves++;
        end
        @(negedge clk);
        check_outputs("post_commit");
        check("busy_judge", 32'(bus_if.busy), 32'(take));
        if (take) begin
            p = m_turn ? 2 : 1;
            if (m_has_line(p)) begin
                m_res  = m_turn ? 2'b10 : 2'b01;
                m_over = 1'b1;
            end else if (m_moves == 9) begin
                m_res  = 2'b11;
                m_over = 1'b1;
            end else begin
                m_turn = ~m_turn;
            end
        end
        @(negedge clk);
        check_outputs("post_judge");
        check("busy_after", 32'(bus_if.busy), 32'd0);
        bus_if.key_data = 4'd0;
        repeat (2) @(negedge clk);
    endtask

    task automatic new_game();
        @(negedge clk) bus_if.is_main = 1'b1;
        @(negedge clk);
        m_clear();
        check_outputs("menu");
        check("menu_busy", 32'(bus_if.busy), 32'd0);
        bus_if.is_main = 1'b0;
        @(negedge clk);
    endtask

    task automatic play(input int seq [], input int n);
        for (int i = 0; i < n; i++) do_press(4'(seq[i]));
    endtask

    initial begin
        int win_seq  [5] = '{1, 4, 2, 5, 3};
        int draw_seq [9] = '{1, 2, 3, 5, 4, 6, 8, 7, 9};
        int xwin_seq [9] = '{1, 2, 3, 5, 4, 6, 8, 9, 7};
        logic [3:0] rc;

        rst             = 1'b1;
        bus_if.is_main  = 1'b0;
        bus_if.key_data = 4'd7;
        m_clear();
        repeat (3) @(negedge clk);
        check_outputs("reset");
        check("reset_err", 32'(bus_if.err), 32'd0);
        check("reset_busy", 32'(bus_if.busy), 32'd0);

        // A key held across reset release must not count until it is released.
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_outputs("held_key");
        check("held_key_busy", 32'(bus_if.busy), 32'd0);
        bus_if.key_data = 4'd0;
        repeat (2) @(negedge clk);

        do_press(4'd5);
        check("first_move_board", 32'(bus_if.board), 32'h00100);
        check("first_move_turn", 32'(bus_if.is_turn_o), 32'd1);
        check("first_move_cnt", 32'(bus_if.move_cnt), 32'd1);
        do_press(4'd5);
        do_press(4'd12);
        check("dup_board", 32'(bus_if.board), 32'h00100);
        check("dup_cnt", 32'(bus_if.move_cnt), 32'd1);

        // Asynchronous reset mid-game clears outputs without waiting for an edge.
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_board", 32'(bus_if.board), 32'd0);
        check("async_rst_cnt", 32'(bus_if.move_cnt), 32'd0);
        check("async_rst_turn", 32'(bus_if.is_turn_o), 32'd0);
        @(negedge clk) rst = 1'b0;
        m_clear();

        new_game();
        play(win_seq, 5);
        check("xwin_result", 32'(bus_if.result), 32'd1);
        check("xwin_turn", 32'(bus_if.is_turn_o), 32'd0);
        do_press(4'd9);
        check("done_ignored_board", 32'(bus_if.board), 32'(m_board()));

        new_game();
        play(draw_seq, 9);
        check("draw_result", 32'(bus_if.result), 32'd3);
        check("draw_cnt", 32'(bus_if.move_cnt), 32'd9);

        new_game();
        play(xwin_seq, 9);
        check("ninth_win_result", 32'(bus_if.result), 32'd1);

        // Menu request while a move is in COMMIT: everything clears, the move is lost.
        new_game();
        do_press(4'd5);
        @(negedge clk) bus_if.key_data = 4'd1;
        @(posedge clk);
        repeat (3) @(negedge clk);
        check("abort_busy", 32'(bus_if.busy), 32'd1);
        bus_if.is_main = 1'b1;
        @(negedge clk);
        m_clear();
        check_outputs("abort");
        bus_if.is_main  = 1'b0;
        bus_if.key_data = 4'd0;
        repeat (3) @(negedge clk);
        do_press(4'd2);
        check("abort_then_move", 32'(bus_if.board), 32'h04000);

        new_game();
`ifdef MOVE_TIMEOUT_EN
        repeat (15) @(negedge clk);
        check("tmo_before", 32'(bus_if.is_turn_o), 32'd0);
        @(negedge clk);
        check("tmo_forfeit_turn", 32'(bus_if.is_turn_o), 32'd1);
        check("tmo_forfeit_board", 32'(bus_if.board), 32'd0);
        check("tmo_forfeit_cnt", 32'(bus_if.move_cnt), 32'd0);
        m_turn = 1'b1;
        // Press lands exactly on the next expiry cycle; the press must win.
        repeat (13) @(negedge clk);
        do_press(4'd5);
        check("tmo_press_board", 32'(bus_if.board), 32'h00200);
`else
        repeat (40) @(negedge clk);
        check("no_tmo_turn", 32'(bus_if.is_turn_o), 32'd0);
`endif

        for (int g = 0; g < 6; g++) begin
            new_game();
            for (int n = 0; n < 30 && !m_over; n++) begin
                rc = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15))
                                                 : 4'($urandom_range(1, 9));
                do_press(rc);
            end
            do_press(4'($urandom_range(1, 9)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ttt_turn_ctrl.md
TTT_TURN_CTRL -- requirements
Module: ttt_turn_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 250000000, is the per-turn move time limit in clk cycles (10 s at 25 MHz).
REQ-002 Parameter CNT_W, default 28, is the timeout counter width; it SHALL be at least ceil(log2(TIMEOUT_CYCLES+1)).
REQ-003 clk  input  1  system clock; all state changes occur on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 is_main  input  1  1 = main menu shown (game held and cleared); 0 = game screen active.
REQ-006 key_data  input  4  keypad code: 0 = no key, 1..9 = cell, 10..15 = non-cell key.
REQ-007 board  output  18  cell k (1..9): O flag at bit 19-2k, X flag at bit 18-2k.
REQ-008 is_turn_o  output  1  0 = X (P1) to move; 1 = O (P2) to move.
REQ-009 result  output  2  00 in play, 01 X wins, 10 O wins, 11 draw.
REQ-010 move_cnt  output  4  number of committed moves, 0..9.
REQ-011 err  output  1  one-cycle pulse on a rejected press.
REQ-012 busy  output  1  1 while in CHECK, COMMIT or JUDGE.

Function
REQ-013 A press SHALL be detected when the registered key_data changes from 0 to nonzero; a held key SHALL yield exactly one press, and any nonzero-to-nonzero change SHALL NOT count as a press.
REQ-014 The state machine SHALL have states IDLE, WAIT_KEY, CHECK, COMMIT, JUDGE and DONE.
REQ-015 IDLE: board, result and move_cnt are 0 and is_turn_o is 0; the block SHALL go to WAIT_KEY on the first clock with is_main=0.
REQ-016 WAIT_KEY: on a press, the code SHALL be latched and the block SHALL go to CHECK; presses in any other state SHALL be ignored without an err pulse.
REQ-017 CHECK: a code of 10..15, or a cell with either flag set, SHALL pulse err for 1 cycle and return to WAIT_KEY with board, is_turn_o and move_cnt unchanged; otherwise the block SHALL go to COMMIT.
REQ-018 COMMIT: the mover's flag for the cell SHALL be set (O flag if is_turn_o=1, else X flag), move_cnt SHALL be incremented, and the block SHALL go to JUDGE.
REQ-019 Latency: board and move_cnt SHALL update 3 clocks after the edge that samples the press; result and is_turn_o SHALL update 1 clock after that.
REQ-020 JUDGE: the 8 lines (3 rows, 3 columns, 2 diagonals) SHALL be evaluated for the mover only.
REQ-021 JUDGE outcome on a line win: result is 01 for X or 10 for O, and the next state is DONE.
REQ-022 JUDGE outcome with no win and move_cnt=9: result is 11 and the next state is DONE.
REQ-023 JUDGE outcome otherwise: is_turn_o toggles and the next state is WAIT_KEY.
REQ-024 A win on the 9th move SHALL report the win, not a draw.
REQ-025 DONE: all outputs SHALL hold and all presses SHALL be ignored until is_main=1.
REQ-026 is_main=1 in any state SHALL force IDLE on the next clock, aborting any in-flight move; a latched but uncommitted move SHALL be discarded.
REQ-027 err SHALL be 0 in every cycle except the one CHECK-reject cycle.

Reset
REQ-028 rst=1 SHALL immediately force IDLE, board=0, result=00, is_turn_o=0, move_cnt=0, err=0 and busy=0, and SHALL clear the press edge register and the timeout counter.
REQ-029 After rst deasserts, a key already held SHALL NOT register as a press until it has been released.

Configuration
REQ-030 With MOVE_TIMEOUT_EN defined, a counter SHALL run only in WAIT_KEY and SHALL clear on every entry to WAIT_KEY.
REQ-031 With MOVE_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES-1 with no press, is_turn_o SHALL toggle (forfeited turn) with board and move_cnt unchanged, and the counter SHALL restart.
REQ-032 With MOVE_TIMEOUT_EN defined, a press sampled in the same cycle as expiry SHALL win: the block goes to CHECK and no forfeit occurs.
REQ-033 Without MOVE_TIMEOUT_EN, no counter logic SHALL exist, and WAIT_KEY SHALL wait indefinitely.

Verification
REQ-034 Reset, is_main=0, press 5 -> board=18'h00100 (bit 8, X) after 3 clocks; is_turn_o=1 and move_cnt=1 one clock later.
REQ-035 Press 5 then 5 again -> one err pulse on the second press; board, is_turn_o and move_cnt unchanged.
REQ-036 Presses 1,4,2,5,3 (X,O,X,O,X) -> result=01, state DONE, is_turn_o=0; a further press 9 is ignored.
REQ-037 Presses 1,2,3,5,4,6,8,7,9 -> result=11, move_cnt=9; with the last move changed so X completes a line -> result=01.
REQ-038 is_main pulsed high while busy=1 -> next clock board=0, result=00, is_turn_o=0, move_cnt=0.
REQ-039 With MOVE_TIMEOUT_EN and TIMEOUT_CYCLES=16, no press for 16 clocks in WAIT_KEY -> is_turn_o toggles and board is unchanged; a press on the expiry cycle -> no toggle.
